cnn_pool_relu: RTL and testbench

- Post-convolution stage between the conv array's per-channel outputs and the result write-back FIFOs.
- Takes one conv output pixel per handshake, CH channels wide, in raster order. Applies an optional ReLU, then 2x2 max-pooling with stride 2.
- Emits one pooled pixel per 2x2 window over a valid/ready stream, with a last-pixel marker.
- Frame geometry is configured per layer through a one-cycle config strobe.

---
 rtl/cnn_pkg.sv | 24 ++
 rtl/cnn_pool_rowbuf.sv | 25 ++
 rtl/cnn_pool_relu.sv | 166 ++++++++++++++++
 tb/tb_cnn_pool_relu.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN post-convolution pool/ReLU stage.
// Channel defaults follow the weight-kernel count of the conv array.
package cnn_pkg;

    localparam int WEIGHT_SIZE = 4;
    localparam int CH_DEF      = WEIGHT_SIZE;
    localparam int DATA_W_DEF  = 32;
    localparam int SMAX_W      = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } pool_state_t;

    function automatic logic signed [SMAX_W-1:0] smax(
        input logic signed [SMAX_W-1:0] a,
        input logic signed [SMAX_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cnn_pool_rowbuf.sv
// Half-row buffer holding the horizontal max of each even-row column pair.
// One write port and one combinational read port share the same index.
module cnn_pool_rowbuf #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/cnn_pool_relu.sv
// Optional ReLU followed by 2x2/stride-2 max-pooling over a raster pixel stream.
// A single output register; a full, non-draining register stalls the input.
module cnn_pool_relu
    import cnn_pkg::*;
#(
    parameter int CH     = CH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int MAX_W  = 64,
    parameter int DIM_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    input  logic [DIM_W-1:0]     cfg_width,
    input  logic [DIM_W-1:0]     cfg_height,
    input  logic                 cfg_relu_en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*DATA_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*DATA_W-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int AW = $clog2(MAX_W / 2);
    localparam int PW = CH * DATA_W;

    pool_state_t state, state_nx;

    logic [DIM_W-1:0] col, row, w_q, h_q;
    logic             relu_q;
    logic [PW-1:0]    hreg, v_vec, hmax_vec, pool_vec, rb_rdata;
    logic             accept, col_odd, row_odd, col_end, row_end;
    logic             pair_row, rb_we, load, last_win;

    assign in_ready   = (state == RUN) && (~out_valid | out_ready);
    assign busy       = (state == RUN) || (state == DRAIN);
    assign frame_done = (state == DONE);

    assign accept  = in_valid && in_ready;
    assign col_odd = col[0];
    assign row_odd = row[0];
    assign col_end = (col == w_q - 1'b1);
    assign row_end = (row == h_q - 1'b1);

    // An even row only feeds the buffer if a partner odd row follows it.
    assign pair_row = row_odd || (({1'b0, row} + 9'd2) <= {1'b0, h_q});
    assign rb_we    = accept && col_odd && !row_odd && pair_row;
    assign load     = accept && col_odd && row_odd;
    assign last_win = (({1'b0, row} + 9'd2) >= {1'b0, h_q}) &&
                      (({1'b0, col} + 9'd2) >= {1'b0, w_q});

    always_comb begin
        logic signed [DATA_W-1:0] x, v, h, r;
        logic signed [SMAX_W-1:0] m, p;
        x        = '0;
        v        = '0;
        h        = '0;
        r        = '0;
        m        = '0;
        p        = '0;
        v_vec    = '0;
        hmax_vec = '0;
        pool_vec = '0;
        for (int c = 0; c < CH; c++) begin
            x = in_data[c*DATA_W +: DATA_W];
            v = (relu_q && x[DATA_W-1]) ? '0 : x;
            h = hreg[c*DATA_W +: DATA_W];
            r = rb_rdata[c*DATA_W +: DATA_W];
            m = smax(SMAX_W'(h), SMAX_W'(v));
            p = smax(SMAX_W'(r), m);
            v_vec[c*DATA_W +: DATA_W]    = v;
            hmax_vec[c*DATA_W +: DATA_W] = m[DATA_W-1:0];
            pool_vec[c*DATA_W +: DATA_W] = p[DATA_W-1:0];
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (cfg_valid) begin
                    state_nx = (cfg_width == '0 || cfg_height == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && col_end && row_end) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid || out_ready) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            w_q       <= '0;
            h_q       <= '0;
            relu_q    <= 1'b0;
            hreg      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && cfg_valid) begin
                w_q    <= cfg_width;
                h_q    <= cfg_height;
                relu_q <= cfg_relu_en;
                col    <= '0;
                row    <= '0;
            end
            if (accept) begin
                if (!col_odd) begin
                    hreg <= v_vec;
                end
                if (col_end) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            // Reload on the same edge as an accept keeps the stream bubble-free.
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= pool_vec;
                out_last  <= last_win;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && state == IDLE && cfg_valid) begin
            assert (int'(cfg_width) <= MAX_W);
        end
    end

    cnn_pool_rowbuf #(
        .DEPTH (MAX_W / 2),
        .WIDTH (PW),
        .AW    (AW)
    ) u_rowbuf (
        .clk   (clk),
        .we    (rb_we),
        .addr  (col[AW:1]),
        .wdata (hmax_vec),
        .rdata (rb_rdata)
    );

endmodule

// File: tb/tb_cnn_pool_relu.sv
// Directed bench for cnn_pool_relu: frames of various geometry, ReLU,
// backpressure, mid-frame reset and empty-frame configuration.
module tb_cnn_pool_relu;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_valid;
    logic [7:0]   cfg_width;
    logic [7:0]   cfg_height;
    logic         cfg_relu_en;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;
    logic         busy;
    logic         frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    int done_total = 0;
    int pix[$];
    int expv[$];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) done_total++;
    end

    cnn_pool_relu dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_width   (cfg_width),
        .cfg_height  (cfg_height),
        .cfg_relu_en (cfg_relu_en),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rep(input int v);
        return {4{v}};
    endfunction

    task automatic ramp(input int n);
        pix.delete();
        for (int i = 0; i < n; i++) pix.push_back(i);
    endtask

    task automatic do_cfg(input int w, input int h, input bit relu);
        @(negedge clk);
        cfg_valid   = 1'b1;
        cfg_width   = 8'(w);
        cfg_height  = 8'(h);
        cfg_relu_en = relu;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic run_frame(input int w, input int h, input bit relu,
                             input int stall, input string tag);
        int  idx = 0;
        int  oidx = 0;
        int  cyc = 0;
        int  acc_cyc = -1;
        int  done_cyc = -1;
        int  dones = 0;
        int  stall_left = stall;
        bit  seen_ov = 1'b0;
        bit  rdy_any = 1'b0;
        bit  acc;
        do_cfg(w, h, relu);
        while (cyc < 400) begin
            in_valid = (idx < pix.size());
            in_data  = (idx < pix.size()) ? rep(pix[idx]) : '0;
            if (out_valid) seen_ov = 1'b1;
            out_ready = !(seen_ov && stall_left > 0);
            if (seen_ov && stall_left > 0) stall_left--;
            #1;
            if (in_ready) rdy_any = 1'b1;
            if (out_valid && !out_ready && oidx < expv.size()) begin
                chk({tag, "_stall_rdy"}, 128'(in_ready), 128'(0));
                chk({tag, "_stall_hold"}, out_data, rep(expv[oidx]));
            end
            if (frame_done) begin
                dones++;
                done_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                if (oidx < expv.size()) begin
                    chk({tag, "_data"}, out_data, rep(expv[oidx]));
                    chk({tag, "_last"}, 128'(out_last),
                        128'(oidx == expv.size() - 1));
                end else begin
                    chk({tag, "_extra_out"}, 128'(oidx), 128'(expv.size()));
                end
                oidx++;
            end
            acc = in_valid && in_ready;
            if (acc && idx == pix.size() - 1) acc_cyc = cyc;
            @(posedge clk);
            if (acc) idx++;
            cyc++;
            @(negedge clk);
            if (done_cyc >= 0 && cyc > done_cyc + 2) break;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_n_out"}, 128'(oidx), 128'(expv.size()));
        chk({tag, "_n_in"}, 128'(idx), 128'(pix.size()));
        chk({tag, "_done_cnt"}, 128'(dones), 128'(1));
        chk({tag, "_busy_end"}, 128'(busy), 128'(0));
        if (stall == 0 && pix.size() > 0)
            chk({tag, "_done_lat"}, 128'(done_cyc - acc_cyc), 128'(2));
        if (pix.size() == 0) begin
            chk({tag, "_no_rdy"}, 128'(rdy_any), 128'(0));
            chk({tag, "_done_early"}, 128'(done_cyc < 3), 128'(1));
        end
    endtask

    initial begin
        int d0;
        int n;
        bit acc;
        rst = 1'b0;
        cfg_valid = 1'b0;
        cfg_width = '0;
        cfg_height = '0;
        cfg_relu_en = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_last", 128'(out_last), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_frame_done", 128'(frame_done), 128'(0));
        rst = 1'b1;

        ramp(16);
        expv = '{5, 7, 13, 15};
        run_frame(4, 4, 1'b0, 0, "f4x4");

        pix = '{-3, -8, -1, -2};
        expv = '{0};
        run_frame(2, 2, 1'b1, 0, "relu_on");
        expv = '{-1};
        run_frame(2, 2, 1'b0, 0, "relu_off");

        ramp(15);
        expv = '{6, 8};
        run_frame(5, 3, 1'b0, 0, "f5x3");

        ramp(16);
        expv = '{5, 7, 13, 15};
        run_frame(4, 4, 1'b0, 10, "bp");

        d0 = done_total;
        do_cfg(4, 4, 1'b0);
        out_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 20 && n < 6; k++) begin
            in_valid = 1'b1;
            in_data  = rep(n);
            #1;
            acc = in_ready;
            @(posedge clk);
            if (acc) n++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("rst_pre_n", 128'(n), 128'(6));
        chk("rst_pre_ov", 128'(out_valid), 128'(1));
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("rst_mid_busy", 128'(busy), 128'(0));
        chk("rst_mid_ov", 128'(out_valid), 128'(0));
        pix = '{1, 2, 3, 4};
        expv = '{4};
        run_frame(2, 2, 1'b0, 0, "rst_2x2");
        chk("rst_done_total", 128'(done_total - d0), 128'(1));

        pix.delete();
        expv.delete();
        run_frame(4, 0, 1'b0, 0, "h0");

        ramp(3);
        expv.delete();
        run_frame(1, 3, 1'b0, 0, "w1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
